// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the instruction ROM and buffers words in a prefetch FIFO.
// Optional build macro IFETCH_PERF_CNT_EN adds saturating fetch/flush performance counters.
module instr_fetch_ctrl #(
    parameter int                  PC_WIDTH   = 16,
    parameter int                  DATA_WIDTH = 16,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic [PC_WIDTH-1:0]   mem_pc,
    input  logic [DATA_WIDTH-1:0] mem_instr,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]   instr_pc,
    output logic                  fifo_full,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_flush_cnt,
`endif
    output logic                  dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                state_q;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic [AW-1:0]         wr_q, wr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem_q    [FIFO_DEPTH];
    logic                  push, pop;

    // Handshake: an entry moves to decode on any cycle where instr_valid and instr_ready are both high.
    assign pop  = instr_valid && instr_ready;
    assign push = (state_q == ST_RUN) && fetch_en && !redirect_valid
                  && ((count_q < DEPTH_C) || pop);

    always_comb begin
        pc_d    = pc_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (redirect_valid) begin
            // Targets are halfword aligned; bit 0 of the request is dropped.
            pc_d    = redirect_pc & {{(PC_WIDTH-1){1'b1}}, 1'b0};
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d = pc_q + PC_WIDTH'(2);
                wr_d = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= fetch_en ? ST_RUN : ST_HALT;
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_RUN:  if (!fetch_en) state_q <= ST_HALT;
                ST_HALT: if (fetch_en)  state_q <= ST_RUN;
                default: state_q <= ST_HALT;
            endcase
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_mem_q[wr_q] <= mem_instr;
            pc_mem_q[wr_q]    <= pc_q;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (push && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (redirect_valid && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

    assign mem_pc      = pc_q;
    assign instr_valid = (count_q != '0);
    assign fifo_full   = (count_q == DEPTH_C);
    assign instr       = instr_mem_q[rd_q];
    assign instr_pc    = pc_mem_q[rd_q];
    assign dbg_state   = state_q;

endmodule
